// File: rtl/fan_speed_ramp_if.sv
// Target-speed command channel between the fan control logic and fan_speed_ramp.
interface fan_speed_ramp_if;
    logic        cmd_valid;
    logic [11:0] cmd_speed;
    logic        cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_speed,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_speed,
        output cmd_ready
    );
endinterface

// File: rtl/fan_speed_ramp.sv
// Slew-rate limiter for the 12-bit PWM speed command, one STEP per RAMP_DIV clocks.
// Optional standstill kick-start is compiled in with FAN_SPEED_RAMP_KICK_EN.
module fan_speed_ramp #(
    parameter int unsigned RAMP_DIV   = 2500,
    parameter int unsigned STEP       = 1,
    parameter int unsigned MAX_SPEED  = 100,
    parameter int unsigned KICK_SPEED = 100,
    parameter int unsigned KICK_TICKS = 250
) (
    input  logic                clk,
    input  logic                rst,
    fan_speed_ramp_if.slave     cmd,
    output logic [11:0]         speed,
    output logic                busy,
    output logic                at_target
);

    localparam int unsigned CW = $clog2(RAMP_DIV);
    localparam logic [11:0] MAX_V  = 12'(MAX_SPEED);
    localparam logic [11:0] STEP_V = 12'((STEP > 4095) ? 4095 : STEP);

    if (RAMP_DIV < 2 || STEP < 1 || MAX_SPEED > 4095 ||
        KICK_TICKS < 1 || KICK_SPEED > 4095) begin : g_param_check
        $error("fan_speed_ramp: parameter out of range");
    end

`ifdef FAN_SPEED_RAMP_KICK_EN
    localparam int unsigned KW = $clog2(KICK_TICKS + 1);
    localparam logic [11:0] KICK_V = (KICK_SPEED > MAX_SPEED) ? MAX_V : 12'(KICK_SPEED);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        KICK = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1
    } state_t;
`endif

    state_t         state, state_nx;
    logic [CW-1:0]  tick_cnt;
    logic           tick;
    logic [11:0]    target, target_nx;
    logic [11:0]    speed_nx;
    logic [11:0]    req_clamped;
    logic           accept;
    logic           up;
    logic [11:0]    diff;
    logic           near;
    logic [11:0]    stepped;

`ifdef FAN_SPEED_RAMP_KICK_EN
    logic [KW-1:0]  kick_cnt, kick_nx;
`endif

    // Free-running tick prescaler, never touched by the FSM.
    assign tick = (tick_cnt == CW'(RAMP_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

`ifdef FAN_SPEED_RAMP_KICK_EN
    assign cmd.cmd_ready = (state != KICK);
`else
    assign cmd.cmd_ready = 1'b1;
`endif

    assign accept      = cmd.cmd_valid && cmd.cmd_ready;
    assign req_clamped = (cmd.cmd_speed > MAX_V) ? MAX_V : cmd.cmd_speed;

    // Step arithmetic always uses the registered target, so a retarget
    // landing on a tick only takes effect from the following tick.
    assign up      = (target > speed);
    assign diff    = up ? (target - speed) : (speed - target);
    assign near    = (diff <= STEP_V);
    assign stepped = near ? target : (up ? (speed + STEP_V) : (speed - STEP_V));

    always_comb begin
        state_nx  = state;
        speed_nx  = speed;
        target_nx = target;
`ifdef FAN_SPEED_RAMP_KICK_EN
        kick_nx   = kick_cnt;
`endif
        if (accept) begin
            target_nx = req_clamped;
        end

        case (state)
            IDLE: begin
                if (accept && (req_clamped != speed)) begin
`ifdef FAN_SPEED_RAMP_KICK_EN
                    if (speed == '0) begin
                        state_nx = KICK;
                        speed_nx = KICK_V;
                        kick_nx  = KW'(KICK_TICKS);
                    end else begin
                        state_nx = RAMP;
                    end
`else
                    state_nx = RAMP;
`endif
                end
            end

            RAMP: begin
                if (tick) begin
                    speed_nx = stepped;
                    // A fresh accept keeps us ramping so the new target is evaluated next tick.
                    if (near && !accept) begin
                        state_nx = IDLE;
                    end
                end
            end

`ifdef FAN_SPEED_RAMP_KICK_EN
            KICK: begin
                if (tick) begin
                    kick_nx = kick_cnt - KW'(1);
                    if (kick_cnt == KW'(1)) begin
                        state_nx = RAMP;
                    end
                end
            end
`endif

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            speed  <= '0;
            target <= '0;
        end else begin
            state  <= state_nx;
            speed  <= speed_nx;
            target <= target_nx;
        end
    end

`ifdef FAN_SPEED_RAMP_KICK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kick_cnt <= '0;
        end else begin
            kick_cnt <= kick_nx;
        end
    end
`endif

    assign busy      = (state != IDLE);
    assign at_target = (speed == target);

    a_speed_bounded: assert property (@(posedge clk) disable iff (rst) speed <= MAX_V);
    a_idle_settled:  assert property (@(posedge clk) disable iff (rst) (state == IDLE) |-> (speed == target));

endmodule

// File: tb/tb_fan_speed_ramp.sv
// Self-checking bench for fan_speed_ramp: directed sequences, a vector table and
// randomized traffic compared every cycle against a behavioural model.
module tb_fan_speed_ramp;

    localparam int RD   = 4;
    localparam int MAXS = 100;
    localparam int KS   = 100;
    localparam int KT   = 3;
`ifdef FAN_SPEED_RAMP_KICK_EN
    localparam int ST   = 1;
    localparam bit KEN  = 1'b1;
`else
    localparam int ST   = 3;
    localparam bit KEN  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] speed;
    logic        busy;
    logic        at_target;

    fan_speed_ramp_if bus ();

    fan_speed_ramp #(
        .RAMP_DIV  (RD),
        .STEP      (ST),
        .MAX_SPEED (MAXS),
        .KICK_SPEED(KS),
        .KICK_TICKS(KT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (bus),
        .speed    (speed),
        .busy     (busy),
        .at_target(at_target)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural reference: plain integer arithmetic on speed/target/kick time left.
    int m_speed, m_target, m_phase, m_kick;
    bit m_ramping, m_last_tick;
    bit m_tick, m_acc;
    int m_nt, m_dist, m_stepped;

    always_comb begin
        m_tick  = (m_phase == RD - 1);
        m_acc   = bus.cmd_valid && (m_kick == 0);
        m_nt    = (int'(bus.cmd_speed) > MAXS) ? MAXS : int'(bus.cmd_speed);
        m_dist  = m_target - m_speed;
        if (m_dist <= ST && m_dist >= -ST) m_stepped = m_target;
        else if (m_dist > 0)               m_stepped = m_speed + ST;
        else                               m_stepped = m_speed - ST;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_speed     <= 0;
            m_target    <= 0;
            m_phase     <= 0;
            m_kick      <= 0;
            m_ramping   <= 1'b0;
            m_last_tick <= 1'b0;
        end else begin
            m_phase     <= m_tick ? 0 : m_phase + 1;
            m_last_tick <= m_tick;
            if (m_acc) m_target <= m_nt;
            if (m_kick > 0) begin
                if (m_tick) begin
                    m_kick <= m_kick - 1;
                    if (m_kick == 1) m_ramping <= 1'b1;
                end
            end else if (m_ramping) begin
                if (m_tick) begin
                    m_speed <= m_stepped;
                    if (m_stepped == m_target && !m_acc) m_ramping <= 1'b0;
                end
            end else if (m_acc && m_nt != m_speed) begin
                if (KEN && m_speed == 0) begin
                    m_speed <= (KS > MAXS) ? MAXS : KS;
                    m_kick  <= KT;
                end else begin
                    m_ramping <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_speed", int'(speed), m_speed);
            chk("model_ready", int'(bus.cmd_ready), int'(m_kick == 0));
            chk("model_busy", int'(busy), int'(m_ramping || m_kick > 0));
            chk("model_at_target", int'(at_target), int'(m_speed == m_target));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int v);
        bus.cmd_valid = 1'b1;
        bus.cmd_speed = 12'(v);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int mx, output int ticks);
        int n;
        n = 0;
        mx = int'(speed);
        ticks = 0;
        while (busy && n < budget) begin
            step();
            n++;
            ticks += int'(m_last_tick);
            if (int'(speed) > mx) mx = int'(speed);
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    typedef struct {
        int cmd;
        int exp_final;
        bit exp_busy;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int q[$];
        int e[$];
        int mx, ticks, k, last, nbad, s0;

        tbl[0] = '{cmd: 4095, exp_final: 100, exp_busy: 1'b1};
        tbl[1] = '{cmd: 30,   exp_final: 30,  exp_busy: 1'b1};
        tbl[2] = '{cmd: 200,  exp_final: 100, exp_busy: 1'b1};
        tbl[3] = '{cmd: 100,  exp_final: 100, exp_busy: 1'b0};
        tbl[4] = '{cmd: 0,    exp_final: 0,   exp_busy: 1'b1};
        tbl[5] = '{cmd: 60,   exp_final: 60,  exp_busy: 1'b1};

        // Reset with a command pending
        bus.cmd_valid = 1'b1;
        bus.cmd_speed = 12'd40;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_speed", int'(speed), 0);
        chk("rst_ready", int'(bus.cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_at_target", int'(at_target), 1);
        bus.cmd_valid = 1'b0;
        rst = 1'b0;
        repeat (10) step();
        chk("idle_speed", int'(speed), 0);

        // Start from standstill to 50
        accept(50);
        if (KEN) begin
            chk("kick_jump", int'(speed), KS);
            chk("kick_ready_low", int'(bus.cmd_ready), 0);
            k = 0;
            for (int i = 0; i < 50 && !bus.cmd_ready; i++) begin
                step();
                k += int'(m_last_tick);
            end
            chk("kick_ticks", k, KT);
            chk("kick_end_speed", int'(speed), KS);
            for (int v = KS - 1; v >= 50; v--) e.push_back(v);
        end else begin
            for (int v = ST; v < 50; v += ST) e.push_back(v);
            e.push_back(50);
        end
        last = int'(speed);
        ticks = 0;
        for (int i = 0; i < 2000 && busy; i++) begin
            step();
            ticks += int'(m_last_tick);
            if (int'(speed) != last) begin
                last = int'(speed);
                q.push_back(last);
            end
        end
        chk("ramp_seq_len", q.size(), e.size());
        nbad = 0;
        for (int i = 0; i < q.size() && i < e.size(); i++) if (q[i] != e[i]) nbad++;
        chk("ramp_seq_values", nbad, 0);
        chk("ramp_ticks", ticks, KEN ? (KS - 50) : 17);
        chk("ramp_busy_end", int'(busy), 0);
        chk("ramp_at_target_end", int'(at_target), 1);

        // Vector table
        for (int i = 0; i < 6; i++) begin
            accept(tbl[i].cmd);
            chk("tbl_busy", int'(busy), int'(tbl[i].exp_busy));
            wait_idle(2000, mx, ticks);
            chk("tbl_final", int'(speed), tbl[i].exp_final);
            chk("tbl_never_above_max", int'(mx <= MAXS), 1);
        end

        // Retarget downward while ramping up
        accept(30);
        wait_idle(2000, mx, ticks);
        accept(80);
        for (int i = 0; i < 50 && int'(speed) <= 30; i++) step();
        chk("retarget_ramping", int'(speed > 12'd30), 1);
        repeat ($urandom_range(0, 3)) step();
        s0 = int'(speed);
        accept(20);
        wait_idle(2000, mx, ticks);
        chk("retarget_final", int'(speed), 20);
        chk("retarget_peak", int'(mx <= s0 + 2 * ST), 1);

        // Asynchronous reset while kicking (or ramping without kick)
        accept(0);
        wait_idle(2000, mx, ticks);
        accept(50);
        repeat (2) step();
        chk("pre_rst_busy", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_speed", int'(speed), 0);
        chk("async_rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) step();
        chk("post_rst_speed", int'(speed), 0);
        accept(50);
        chk("rekick_speed", int'(speed), KEN ? KS : 0);
        chk("rekick_busy", int'(busy), 1);
        wait_idle(2000, mx, ticks);
        chk("rekick_final", int'(speed), 50);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bus.cmd_valid = ($urandom_range(0, 99) < 20);
            case ($urandom_range(0, 3))
                0:       bus.cmd_speed = 12'($urandom_range(0, 4095));
                1:       bus.cmd_speed = 12'($urandom_range(0, 120));
                2:       bus.cmd_speed = speed;
                default: bus.cmd_speed = 12'd0;
            endcase
            step();
            if ($urandom_range(0, 399) == 0) begin
                #2;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        end
        bus.cmd_valid = 1'b0;
        wait_idle(3000, mx, ticks);
        chk("random_settled_at_target", int'(at_target), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
